// File: rtl/slide_calc_pkg.sv
// Shared constants for slide_calc: active-low seven-segment glyphs and the FSM state type.
package slide_calc_pkg;

    localparam logic [7:0] BLANK  = 8'hFF;
    localparam logic [7:0] MINUS  = 8'hBF;
    localparam logic [7:0] CHAR_A = 8'h88;
    localparam logic [7:0] CHAR_S = 8'h92;
    localparam logic [7:0] CHAR_O = 8'hC0;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    typedef enum logic [1:0] {IDLE, CALC, CONVERT} state_t;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = SEG_0;
            4'd1:    seg_digit = SEG_1;
            4'd2:    seg_digit = SEG_2;
            4'd3:    seg_digit = SEG_3;
            4'd4:    seg_digit = SEG_4;
            4'd5:    seg_digit = SEG_5;
            4'd6:    seg_digit = SEG_6;
            4'd7:    seg_digit = SEG_7;
            4'd8:    seg_digit = SEG_8;
            4'd9:    seg_digit = SEG_9;
            default: seg_digit = BLANK;
        endcase
    endfunction

endpackage

// File: rtl/slide_calc_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, symmetric stability counter and a
// one-cycle pulse when a press (high-to-low) is accepted.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // The counter runs only while the synchronised level differs from the accepted
    // level, so both press and release must hold for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
                r_press  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/slide_calc.sv
// Switch-operand adder/subtractor with debounced keys, sequential double-dabble and
// sign/tens/ones/op/overflow shown on the DE10-Lite seven-segment displays.
module slide_calc
    import slide_calc_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET,
    input  logic [9:0] SW,
    input  logic [1:0] KEY,
    input  logic       MODE,
    output logic [7:0] HEX5,
    output logic [7:0] HEX4,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic [9:0] LEDR
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH + 1);

    logic w_press1, w_press0, w_press_any;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .i_clk   (MAX10_CLK1_50),
        .i_rst   (RESET),
        .i_key_n (KEY[1]),
        .o_press (w_press1)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .i_clk   (MAX10_CLK1_50),
        .i_rst   (RESET),
        .i_key_n (KEY[0]),
        .o_press (w_press0)
    );

    assign w_press_any = w_press1 | w_press0;

    if (2 * WIDTH < 10) begin : g_sw_unused
        logic w_unused_sw;
        assign w_unused_sw = ^SW[9:2*WIDTH];
    end

    state_t           r_state, w_state_d;
    logic             w_done;
    logic [WIDTH-1:0] r_x, r_y;
    logic             r_op, r_pending;
    logic             r_neg, r_calc_ovf, r_calc_op;
    logic [WIDTH+1:0] r_bin;
    logic [3:0]       r_tens, r_ones;
    logic [CNT_W-1:0] r_cnt;
    logic             r_d_neg, r_d_sub, r_d_ovf;
    logic [3:0]       r_d_tens, r_d_ones;

    logic [WIDTH+1:0] w_x_ext, w_y_ext, w_res, w_mag;
    logic             w_ovf;
    logic [3:0]       w_tens_adj, w_ones_adj;
    logic [WIDTH+9:0] w_dd;

    assign w_x_ext = MODE ? {{2{r_x[WIDTH-1]}}, r_x} : {2'b00, r_x};
    assign w_y_ext = MODE ? {{2{r_y[WIDTH-1]}}, r_y} : {2'b00, r_y};
    assign w_res   = r_op ? (w_x_ext - w_y_ext) : (w_x_ext + w_y_ext);
    assign w_mag   = w_res[WIDTH+1] ? -w_res : w_res;
    // Signed: the top three bits must agree; unsigned: anything at or above bit WIDTH.
    assign w_ovf   = MODE ? ~((&w_res[WIDTH+1:WIDTH-1]) | ~(|w_res[WIDTH+1:WIDTH-1]))
                          : (|w_res[WIDTH+1:WIDTH]);

    assign w_ones_adj = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
    assign w_tens_adj = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
    assign w_dd       = {w_tens_adj, w_ones_adj, r_bin} << 1;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_done    = 1'b0;
        case (r_state)
            IDLE:    if (r_pending || w_press_any) w_state_d = CALC;
            CALC:    w_state_d = CONVERT;
            CONVERT: begin
                if (r_cnt == LAST) begin
                    w_done    = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            r_x        <= '0;
            r_y        <= '0;
            r_op       <= 1'b0;
            r_pending  <= 1'b0;
            r_neg      <= 1'b0;
            r_calc_ovf <= 1'b0;
            r_calc_op  <= 1'b0;
            r_bin      <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
            r_cnt      <= '0;
            r_d_neg    <= 1'b0;
            r_d_sub    <= 1'b0;
            r_d_ovf    <= 1'b0;
            r_d_tens   <= '0;
            r_d_ones   <= '0;
        end else begin
            if (w_press1) begin
                r_x <= SW[2*WIDTH-1:WIDTH];
                r_y <= SW[WIDTH-1:0];
            end
            if (w_press0) r_op <= ~r_op;
            // IDLE consumes any request directly; while busy, requests collapse into one.
            if (r_state == IDLE)  r_pending <= 1'b0;
            else if (w_press_any) r_pending <= 1'b1;

            if (r_state == CALC) begin
                r_neg      <= w_res[WIDTH+1];
                r_bin      <= w_mag;
                r_tens     <= '0;
                r_ones     <= '0;
                r_cnt      <= '0;
                r_calc_ovf <= w_ovf;
                r_calc_op  <= r_op;
            end else if (r_state == CONVERT) begin
                r_bin  <= w_dd[WIDTH+1:0];
                r_ones <= w_dd[WIDTH+5:WIDTH+2];
                r_tens <= w_dd[WIDTH+9:WIDTH+6];
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_done) begin
                    r_d_neg  <= r_neg;
                    r_d_tens <= w_dd[WIDTH+9:WIDTH+6];
                    r_d_ones <= w_dd[WIDTH+5:WIDTH+2];
                    r_d_sub  <= r_calc_op;
                    r_d_ovf  <= r_calc_ovf;
                end
            end
        end
    end

    assign HEX5 = r_d_neg ? MINUS : BLANK;
    assign HEX4 = (r_d_tens == 4'd0) ? BLANK : seg_digit(r_d_tens);
    assign HEX3 = seg_digit(r_d_ones);
    assign HEX2 = BLANK;
    assign HEX1 = r_d_sub ? CHAR_S : CHAR_A;
    assign HEX0 = r_d_ovf ? CHAR_O : BLANK;
    assign LEDR = {(r_state != IDLE), 7'b0, r_op, r_d_ovf};

endmodule
